// File: rtl/simple_cpu_gen.sv
// rtl/simple_cpu_gen.sv - multi-cycle accumulator CPU with memory-ready stall handshake
module simple_cpu_gen #(
    parameter int DW      = 16,
    parameter int AW      = 13,
    parameter int W_ADDR  = 1000,
    parameter int IND_PTR = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          memReady,
    input  logic [DW-1:0] data_fromRAM,
    output logic          wrEn,
    output logic [AW-1:0] addr_toRAM,
    output logic [DW-1:0] data_toRAM,
    output logic [AW-1:0] pCounter,
    output logic [2:0]    state,
    output logic          halted
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_DEC   = 3'd1,
        S_A     = 3'd2,
        S_IND   = 3'd3,
        S_WR    = 3'd4,
        S_EXEC  = 3'd5,
        S_HALT  = 3'd6,
        S_ILL   = 3'd7
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_NAND = 3'd1;
    localparam logic [2:0] OP_SRL  = 3'd2;
    localparam logic [2:0] OP_LT   = 3'd3;
    localparam logic [2:0] OP_BZ   = 3'd4;
    localparam logic [2:0] OP_CP2W = 3'd5;
    localparam logic [2:0] OP_CPFW = 3'd6;
    localparam logic [2:0] OP_MUL  = 3'd7;

    localparam logic [AW-1:0] L_W_ADDR  = AW'(W_ADDR);
    localparam logic [AW-1:0] L_IND_PTR = AW'(IND_PTR);
    // Shift thresholds carry one extra bit so 2*DW is representable
    localparam logic [DW:0]   L_DW      = (DW+1)'(DW);
    localparam logic [DW:0]   L_2DW     = (DW+1)'(2*DW);

    state_t        r_state;
    logic [AW-1:0] r_pc;
    logic [2:0]    r_op;
    logic [AW-1:0] r_arg;
    logic [AW-1:0] r_ea;
    logic [DW-1:0] r_opA;
    logic [DW-1:0] r_wv;
    logic          r_halted;

    state_t        w_next_state;
    logic          w_advance;
    logic          w_wr_en;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    logic [DW-1:0] w_result;
    logic [AW-1:0] w_next_pc;
    logic          w_bz_halt;
    logic [2:0]    w_in_op;
    logic [AW-1:0] w_in_arg;
    logic [DW:0]   w_opA_ext;
    logic [DW-1:0] w_shift_hi;

    // Instruction fields are taken straight off the read bus while decoding
    assign w_in_op    = data_fromRAM[DW-1:DW-3];
    assign w_in_arg   = data_fromRAM[AW-1:0];
    assign w_opA_ext  = {1'b0, r_opA};
    assign w_shift_hi = r_opA - DW'(DW);

    // ALU result and branch decision for the latched instruction
    always_comb begin
        w_result  = '0;
        w_next_pc = r_pc + AW'(1);
        w_bz_halt = 1'b0;
        case (r_op)
            OP_ADD:  w_result = r_wv + r_opA;
            OP_NAND: w_result = ~(r_wv & r_opA);
            OP_SRL: begin
                if (w_opA_ext < L_DW)
                    w_result = r_wv >> r_opA;
                else if (w_opA_ext < L_2DW)
                    w_result = r_wv << w_shift_hi;
                else
                    w_result = '0;
            end
            OP_LT:   w_result = {{(DW-1){1'b0}}, (r_wv < r_opA)};
            OP_CP2W: w_result = r_opA;
            OP_CPFW: w_result = r_wv;
            OP_MUL:  w_result = r_wv * r_opA;
            OP_BZ: begin
                if (r_wv == '0) begin
                    w_next_pc = r_opA[AW-1:0];
                    w_bz_halt = (r_opA[AW-1:0] == r_pc);
                end
            end
            default: w_result = '0;
        endcase
    end

    // Next state, memory access presented in the current state, and stall gating
    always_comb begin
        w_next_state = r_state;
        w_advance    = 1'b0;
        w_wr_en      = 1'b0;
        w_addr       = '0;
        w_wdata      = '0;
        case (r_state)
            S_FETCH: begin
                w_addr       = r_pc;
                w_advance    = memReady;
                w_next_state = S_DEC;
            end
            S_DEC: begin
                w_addr       = (w_in_arg != '0) ? w_in_arg : L_IND_PTR;
                w_advance    = memReady;
                w_next_state = S_A;
            end
            S_A: begin
                w_addr       = (r_arg != '0) ? L_W_ADDR : data_fromRAM[AW-1:0];
                w_advance    = memReady;
                w_next_state = (r_arg != '0) ? S_WR : S_IND;
            end
            S_IND: begin
                w_addr       = L_W_ADDR;
                w_advance    = memReady;
                w_next_state = S_WR;
            end
            S_WR: begin
                w_advance    = 1'b1;
                w_next_state = S_EXEC;
            end
            S_EXEC: begin
                if (r_op == OP_BZ) begin
                    w_advance    = 1'b1;
                    w_next_state = w_bz_halt ? S_HALT : S_FETCH;
                end else begin
                    w_wr_en      = 1'b1;
                    w_addr       = (r_op == OP_CPFW) ? r_ea : L_W_ADDR;
                    w_wdata      = w_result;
                    w_advance    = memReady;
                    w_next_state = S_FETCH;
                end
            end
            S_HALT: begin
                w_next_state = S_HALT;
            end
            default: begin
                w_advance    = 1'b1;
                w_next_state = S_FETCH;
            end
        endcase
    end

    // State and datapath registers; everything holds while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_FETCH;
            r_pc     <= '0;
            r_op     <= '0;
            r_arg    <= '0;
            r_ea     <= '0;
            r_opA    <= '0;
            r_wv     <= '0;
            r_halted <= 1'b0;
        end else if (w_advance) begin
            r_state <= w_next_state;
            case (r_state)
                S_DEC: begin
                    r_op  <= w_in_op;
                    r_arg <= w_in_arg;
                    r_ea  <= w_in_arg;
                end
                S_A: begin
                    if (r_arg != '0)
                        r_opA <= data_fromRAM;
                    else
                        r_ea  <= data_fromRAM[AW-1:0];
                end
                S_IND:  r_opA <= data_fromRAM;
                S_WR:   r_wv  <= data_fromRAM;
                S_EXEC: begin
                    r_pc <= w_next_pc;
                    if (w_next_state == S_HALT)
                        r_halted <= 1'b1;
                end
                S_ILL:  r_pc <= '0;
                default: ;
            endcase
        end
    end

    // Reset forces the visible interface idle in the same cycle
    assign wrEn       = rst ? 1'b0 : w_wr_en;
    assign addr_toRAM = rst ? '0 : w_addr;
    assign data_toRAM = rst ? '0 : w_wdata;
    assign pCounter   = rst ? '0 : r_pc;
    assign state      = rst ? 3'd0 : r_state;
    assign halted     = !rst && r_halted;

endmodule

// File: tb/tb_simple_cpu_gen.sv
// tb/tb_simple_cpu_gen.sv - scoreboard bench for simple_cpu_gen with a behavioural RAM
module tb_simple_cpu_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memReady = 1'b1;
    logic [15:0] data_fromRAM;
    logic        wrEn;
    logic [12:0] addr_toRAM;
    logic [15:0] data_toRAM;
    logic [12:0] pCounter;
    logic [2:0]  state;
    logic        halted;

    logic        clr = 1'b0;
    logic        ld_en = 1'b0;
    logic [12:0] ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic [15:0] mem [0:8191];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_fetch = 0;
    logic [2:0] prev_st = 3'd0;

    int q_wa[$];
    int q_wd[$];
    int q_pc[$];
    int q_st[$];
    int q_lat[$];

    typedef struct {
        logic [15:0] ins;
        logic [15:0] opa;
        logic [15:0] wv;
        logic [15:0] res;
    } vec_t;

    vec_t alu_vecs[16];
    vec_t bz_vecs[3];

    simple_cpu_gen #(.DW(16), .AW(13), .W_ADDR(1000), .IND_PTR(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .memReady     (memReady),
        .data_fromRAM (data_fromRAM),
        .wrEn         (wrEn),
        .addr_toRAM   (addr_toRAM),
        .data_toRAM   (data_toRAM),
        .pCounter     (pCounter),
        .state        (state),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 8192; i++) mem[i] <= '0;
            data_fromRAM <= '0;
        end else if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (memReady) begin
            if (wrEn) mem[addr_toRAM] <= data_toRAM;
            else      data_fromRAM <= mem[addr_toRAM];
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_st    = 3'd0;
            last_fetch = cyc + 1;
        end else begin
            if (wrEn && memReady) begin
                if (q_wa.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_write actual=%0h:%0h required=none", addr_toRAM, data_toRAM);
                end else begin
                    chk("wr_addr", int'(addr_toRAM), q_wa.pop_front());
                    chk("wr_data", int'(data_toRAM), q_wd.pop_front());
                end
            end
            if (state != prev_st && (state == 3'd0 || state == 3'd6)) begin
                if (q_pc.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_retire actual=st%0d pc%0h required=none", state, pCounter);
                end else begin
                    chk("ret_pc", int'(pCounter), q_pc.pop_front());
                    chk("ret_state", int'(state), q_st.pop_front());
                    chk("ret_latency", cyc - last_fetch, q_lat.pop_front());
                end
                last_fetch = cyc;
            end
            prev_st = state;
        end
    end

    task automatic expect_wr(input int a, input int d);
        q_wa.push_back(a);
        q_wd.push_back(d);
    endtask

    task automatic expect_ret(input int pc, input int st, input int lat);
        q_pc.push_back(pc);
        q_st.push_back(st);
        q_lat.push_back(lat);
    endtask

    task automatic start_reset();
        rst = 1'b1;
        memReady = 1'b1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic poke(input int a, input int d);
        ld_en = 1'b1;
        ld_addr = 13'(a);
        ld_data = 16'(d);
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((q_wa.size() != 0 || q_pc.size() != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_pending", q_wa.size() + q_pc.size(), 0);
        q_wa.delete(); q_wd.delete();
        q_pc.delete(); q_st.delete(); q_lat.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        alu_vecs[0]  = '{16'h0014, 16'h0007, 16'h0005, 16'h000C};
        alu_vecs[1]  = '{16'h0014, 16'h0002, 16'hFFFF, 16'h0001};
        alu_vecs[2]  = '{16'h2014, 16'hFF00, 16'hF0F0, 16'h0FFF};
        alu_vecs[3]  = '{16'h4014, 16'd1,    16'h8001, 16'h4000};
        alu_vecs[4]  = '{16'h4014, 16'd15,   16'h8001, 16'h0001};
        alu_vecs[5]  = '{16'h4014, 16'd16,   16'h8001, 16'h8001};
        alu_vecs[6]  = '{16'h4014, 16'd17,   16'h8001, 16'h0002};
        alu_vecs[7]  = '{16'h4014, 16'd31,   16'h8001, 16'h8000};
        alu_vecs[8]  = '{16'h4014, 16'd32,   16'h8001, 16'h0000};
        alu_vecs[9]  = '{16'h4014, 16'd40,   16'h8001, 16'h0000};
        alu_vecs[10] = '{16'h6014, 16'd5,    16'd3,    16'h0001};
        alu_vecs[11] = '{16'h6014, 16'd3,    16'd5,    16'h0000};
        alu_vecs[12] = '{16'h6014, 16'd5,    16'd5,    16'h0000};
        alu_vecs[13] = '{16'hA014, 16'hBEEF, 16'h1111, 16'hBEEF};
        alu_vecs[14] = '{16'hE014, 16'h0100, 16'h0123, 16'h2300};
        alu_vecs[15] = '{16'hE014, 16'hFFFF, 16'hFFFF, 16'h0001};
        // res holds the expected pCounter after the branch
        bz_vecs[0]   = '{16'h8014, 16'd9,    16'd0,    16'd9};
        bz_vecs[1]   = '{16'h8014, 16'd9,    16'd3,    16'd1};
        bz_vecs[2]   = '{16'h8014, 16'hE009, 16'd0,    16'd9};

        @(posedge clk); #1;
        start_reset();
        @(posedge clk); #1;
        chk("rst_state", int'(state), 0);
        chk("rst_pc", int'(pCounter), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_wren", int'(wrEn), 0);
        chk("rst_addr", int'(addr_toRAM), 0);
        chk("rst_wdata", int'(data_toRAM), 0);

        foreach (alu_vecs[i]) begin
            start_reset();
            poke(0, alu_vecs[i].ins);
            poke(20, alu_vecs[i].opa);
            poke(1000, alu_vecs[i].wv);
            expect_wr(1000, alu_vecs[i].res);
            expect_ret(1, 0, 5);
            rst = 1'b0;
            drain(30);
        end

        foreach (bz_vecs[i]) begin
            start_reset();
            poke(0, bz_vecs[i].ins);
            poke(20, bz_vecs[i].opa);
            poke(1000, bz_vecs[i].wv);
            expect_ret(bz_vecs[i].res, 0, 5);
            rst = 1'b0;
            drain(30);
        end

        start_reset();
        poke(0, 16'hC000);
        poke(4, 50);
        poke(1000, 16'h1234);
        expect_wr(50, 16'h1234);
        expect_ret(1, 0, 6);
        rst = 1'b0;
        drain(30);
        chk("cpfw_dst", int'(mem[50]), 16'h1234);
        chk("cpfw_w_kept", int'(mem[1000]), 16'h1234);

        start_reset();
        poke(0, 16'h0000);
        poke(4, 20);
        poke(20, 7);
        poke(1000, 5);
        expect_wr(1000, 12);
        expect_ret(1, 0, 6);
        rst = 1'b0;
        drain(30);

        start_reset();
        poke(0, 16'h000B);
        poke(1, 16'h000B);
        poke(2, 16'h801E);
        poke(30, 2);
        expect_wr(1000, 0);
        expect_ret(1, 0, 5);
        expect_wr(1000, 0);
        expect_ret(2, 0, 5);
        expect_ret(2, 6, 5);
        rst = 1'b0;
        drain(60);
        for (int i = 0; i < 20; i++) begin
            memReady = i[0];
            @(posedge clk); #1;
            chk("halt_state", int'(state), 6);
            chk("halt_flag", int'(halted), 1);
            chk("halt_pc", int'(pCounter), 2);
        end
        memReady = 1'b1;

        start_reset();
        poke(0, 16'h0014);
        poke(20, 7);
        poke(1000, 5);
        expect_wr(1000, 12);
        expect_ret(1, 0, 8);
        rst = 1'b0;
        chk("post_halt_state", int'(state), 0);
        chk("post_halt_flag", int'(halted), 0);
        chk("post_halt_pc", int'(pCounter), 0);
        @(posedge clk); #1;
        memReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_addr", int'(addr_toRAM), 20);
            chk("stall_state", int'(state), 1);
            @(posedge clk); #1;
        end
        memReady = 1'b1;
        drain(30);

        start_reset();
        poke(0, 16'hE014);
        poke(20, 3);
        poke(1000, 4);
        rst = 1'b0;
        begin
            int n;
            n = 0;
            while (state != 3'd5 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            chk("mul_reach_exec", int'(state), 5);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_state", int'(state), 0);
        chk("abort_pc", int'(pCounter), 0);
        chk("abort_wren", int'(wrEn), 0);
        chk("abort_no_write", int'(mem[1000]), 4);
        expect_wr(1000, 12);
        expect_ret(1, 0, 5);
        drain(30);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/simple_cpu_gen.md
# simple_cpu_gen

Parametrised multi-cycle accumulator CPU, next generation of the team's 16-bit SimpleCPU. Same eight-opcode ISA against a single-port RAM, with a fixed accumulator word W and indirect addressing through a pointer word. Adds configurable data/address width and W/pointer locations, a memory-ready stall handshake, fully defined shift semantics, and a self-branch halt. Sits between the instruction/data RAM and the top-level test harness.

## Interface
- DW, 16: data and instruction width; must satisfy DW >= AW+3
- AW, 13: address width
- W_ADDR, 1000: address of accumulator word W
- IND_PTR, 4: pointer word used when arg == 0
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- memReady  in  1  RAM accepts the presented access on a rising edge where memReady=1
- data_fromRAM  in  DW  read data, valid the cycle after an accepted read; held stable until the next accepted access
- wrEn  out  1  write strobe for the presented access
- addr_toRAM  out  AW  access address
- data_toRAM  out  DW  write data
- pCounter  out  AW  program counter
- state  out  3  current FSM state encoding
- halted  out  1  CPU stopped on a self-branch

## Operation
- Instruction word: opcode = bits [DW-1:DW-3], arg = bits [AW-1:0], bits between are ignored.
- Opcodes: ADD=0, NAND=1, SRL=2, LT=3, BZ=4, CP2W=5, CPfW=6, MUL=7.
- Effective address: ea = arg if arg != 0, else mem[IND_PTR]. Operand opA = mem[ea]. Accumulator wv = mem[W_ADDR].
- States, with encoding on the `state` output:
  - FETCH=0: read pCounter; go to DEC.
  - DEC=1: latch opcode/arg; read arg, or IND_PTR if arg==0; go to A.
  - A=2: if arg!=0, latch opA, read W_ADDR, go to WR. If arg==0, latch ea = data[AW-1:0], read ea, go to IND.
  - IND=3: latch opA; read W_ADDR; go to WR.
  - WR=4: latch wv; no access; go to EXEC.
  - EXEC=5: perform the operation and write (see below); go to FETCH, or to HALT on a halting BZ.
  - HALT=6: no access; halted=1; remain until rst.
  - 7: illegal; go to FETCH, pCounter=0.
- EXEC results are written to W_ADDR, except CPfW, which writes to ea. All results are truncated to DW bits.
  - ADD: wv+opA, modulo 2^DW.
  - NAND: ~(wv&opA).
  - SRL: wv>>opA if opA<DW; wv<<(opA-DW) if DW<=opA<2*DW; 0 otherwise.
  - LT: unsigned (wv<opA), zero-extended.
  - CP2W: opA.
  - CPfW: wv.
  - MUL: low DW bits of wv*opA.
  - BZ: no write (wrEn=0). pCounter = opA[AW-1:0] if wv==0, else pCounter+1.
- pCounter = pCounter+1 for every non-BZ opcode, wrapping modulo 2^AW.
- Halt condition: BZ taken (wv==0) with opA[AW-1:0] == the current pCounter.
- When no access is issued (WR, HALT, reset, BZ EXEC): addr_toRAM=0, data_toRAM=0, wrEn=0.

## Timing
- While rst=1: state=FETCH, pCounter=0, halted=0, wrEn=0, addr_toRAM=0, data_toRAM=0, and all internal registers are cleared. The first fetch of address 0 is presented in the first cycle after rst falls.
- rst asserted in any state, including mid-write, aborts the instruction on the next edge. wrEn is 0 during the reset cycle.
- addr_toRAM, wrEn and data_toRAM are combinational from state and internal registers, presented in the same cycle the state is entered.
- Stall: in FETCH, DEC, A, IND, and EXEC when writing, the CPU advances only on an edge with memReady=1. Otherwise state, registers and outputs are held unchanged.
- WR, HALT, and BZ EXEC ignore memReady.
- Latency with no stalls: direct instruction 5 cycles, indirect 6 cycles, FETCH to FETCH. Each memReady=0 cycle adds exactly one cycle.
- pCounter updates on the edge that leaves EXEC. The write lands on that same edge.

## Test plan
- Direct ADD: mem[0]={ADD,20}, mem[20]=7, mem[1000]=5 → after 5 cycles mem[1000]=12, pCounter=1.
- Indirect CPfW: mem[0]={CPfW,0}, mem[4]=50, mem[1000]=0x1234 → mem[50]=0x1234 after 6 cycles. mem[1000] is unchanged.
- SRL bounds, W=0x8001:
  - opA=1 → 0x4000.
  - opA=16 → 0x8001<<0 = 0x8001.
  - opA=17 → 0x0002.
  - opA=40 → 0.
- BZ cases:
  - W=0, target 9 → pCounter=9, no write.
  - W=3 → pCounter+1.
  - At pc=2 with mem[2]={BZ,30}, mem[30]=2, W=0 → state=6, halted=1, held for 20 cycles.
- Stall: memReady=0 for 3 cycles during DEC of a direct ADD → completes in 8 cycles, with addr_toRAM stable throughout.
- Reset: rst pulsed for 1 cycle while in EXEC of MUL → no write, pCounter=0, state=0 on the next cycle. The instruction at 0 re-executes correctly.
